// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: applies a serial pattern to a driven FSM and captures its response; abort support under FSM_SEQ_ABORT_EN
module fsm_seq_ctrl #(
  parameter int PW = 16,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] pat_in,
  input  logic [LW-1:0] len,
  input  logic          fsm_y,
`ifdef FSM_SEQ_ABORT_EN
  input  logic          abort,
  output logic          aborted,
`endif
  output logic          fsm_x,
  output logic          fsm_clr,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] resp,
  output logic [LW-1:0] ones_cnt
);
  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] pat;
  logic [LW-1:0] n, idx, len_c;
  logic stop;
  assign len_c = (len > LW'(PW)) ? LW'(PW) : len;
`ifdef FSM_SEQ_ABORT_EN
  assign stop = abort;
`else
  assign stop = 1'b0;
`endif
  // state register
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  // next state and state-decoded outputs
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    done = state == DONE;
    fsm_x = (state == RUN) && |(pat & (PW'(1) << idx));
    case (state)
      IDLE:    state_n = start ? ((len_c == '0) ? DONE : CLR) : IDLE;
      CLR:     state_n = stop ? DONE : RUN;
      RUN:     state_n = (stop || idx == n - 1'b1) ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  // latched run parameters, bit index, captured response and registered clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat      <= '0;
      n        <= '0;
      idx      <= '0;
      resp     <= '0;
      ones_cnt <= '0;
      fsm_clr  <= 1'b1;
`ifdef FSM_SEQ_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      fsm_clr <= state_n == CLR;
      if (state == IDLE && start) begin
        pat      <= pat_in;
        n        <= len_c;
        idx      <= '0;
        resp     <= '0;
        ones_cnt <= '0;
`ifdef FSM_SEQ_ABORT_EN
        aborted  <= 1'b0;
`endif
      end
      if (state == CLR) idx <= '0;
      if (state == RUN && !stop) begin
        resp     <= resp | (PW'(fsm_y) << idx);
        ones_cnt <= ones_cnt + LW'(fsm_y);
        idx      <= idx + 1'b1;
      end
`ifdef FSM_SEQ_ABORT_EN
      if ((state == CLR || state == RUN) && abort) aborted <= 1'b1;
`endif
    end
  end
endmodule

// File: doc/fsm_seq_ctrl.md
FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

Interface
REQ-001 Parameter PW, default 16, pattern width in bits; legal 2..32.
REQ-002 Parameter LW, default 5, length and count width; LW SHALL equal clog2(PW)+1.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to run one pattern; sampled only in IDLE.
REQ-006 pat_in  input  PW  stimulus bits, applied LSB first.
REQ-007 len  input  LW  number of bits to apply; legal 0..PW; values above PW SHALL be clamped to PW.
REQ-008 fsm_y  input  1  output of the driven sequence FSM.
REQ-009 fsm_x  output  1  serial stimulus bit to the driven FSM.
REQ-010 fsm_clr  output  1  active-high clear to the driven FSM, registered.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 resp  output  PW  captured fsm_y bits; bit k corresponds to stimulus bit k.
REQ-014 ones_cnt  output  LW  number of captured fsm_y bits equal to 1.

Function
REQ-015 States SHALL be IDLE, CLR, RUN and DONE, held in a 2-bit state register.
REQ-016 IDLE with start=1 SHALL latch pat_in and clamped len, clear resp and ones_cnt, and go to CLR; if len=0 it SHALL go directly to DONE instead.
REQ-017 CLR SHALL last exactly one cycle with fsm_clr=1, reset bit index to 0, then go to RUN.
REQ-018 In RUN cycle k, fsm_x SHALL equal pat[k], and on the closing edge resp[k] SHALL take fsm_y and ones_cnt SHALL increment if fsm_y=1.
REQ-019 RUN SHALL last exactly len cycles, then go to DONE.
REQ-020 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-021 Latency from start sampled at edge t: CLR occupies cycle t+1, RUN occupies cycles t+2..t+1+len, and done is high in cycle t+2+len.
REQ-022 Outside RUN, fsm_x SHALL be 0; outside CLR, fsm_clr SHALL be 0.
REQ-023 start while busy=1, including in DONE, SHALL be ignored with no queuing.
REQ-024 resp and ones_cnt SHALL hold their values from done until the next accepted start.
REQ-025 Unused resp bits (index at or above len) SHALL read 0.
REQ-026 ones_cnt SHALL never exceed len and SHALL never wrap.

Reset
REQ-027 rst=0 at a posedge SHALL force IDLE, busy=0, done=0, fsm_x=0, resp=0, ones_cnt=0 and the bit index to 0.
REQ-028 While rst=0, fsm_clr SHALL be 1, so the driven FSM is cleared with the controller.
REQ-029 rst=0 mid-RUN SHALL abandon the run without asserting done.

Configuration
REQ-030 Macro FSM_SEQ_ABORT_EN defined: the block SHALL add an input abort (1 bit) and an output aborted (1 bit); abort=1 in CLR or RUN SHALL go to DONE on the next edge, set aborted=1 and keep the resp bits captured so far; aborted SHALL clear on the next accepted start.
REQ-031 Macro FSM_SEQ_ABORT_EN undefined: abort and aborted SHALL not exist, and every run SHALL complete all len bits.

Verification (driven FSM: 5-state, y=1 only in s0, s0 --x=1--> s1 --x=0--> s2 --x=0--> s4 --x=0--> s0)
REQ-032 pat_in=0x0000, len=4, start -> FSM stays in s0; resp=0x000F, ones_cnt=4, done in cycle t+6.
REQ-033 pat_in=0x0001, len=4 -> states s0, s1, s2, s4; resp=0x0001, ones_cnt=1.
REQ-034 len=0 with start -> fsm_clr never pulses, done in cycle t+1, resp=0, ones_cnt=0.
REQ-035 start pulsed during RUN and again during DONE -> both ignored; exactly one done pulse; next start accepted only from IDLE.
REQ-036 rst=0 in RUN cycle 2 of a len=8 run -> next cycle is IDLE with all outputs 0 and no done pulse.
REQ-037 With FSM_SEQ_ABORT_EN defined: abort in RUN cycle 3 of a len=8 run -> done and aborted in the next cycle; resp bits 3..7 read 0.
